// File: rtl/parity_types_pkg.sv
// Shared types for the parity checker and its stream controller.
package parity_types_pkg;

  typedef enum logic [2:0] {
    EVEN,
    ODD,
    MARK,
    SPACE,
    NONE
  } parity_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN
  } parity_ctrl_state_t;

endpackage

// File: rtl/parity_check_ctrl_if.sv
// Stream, configuration and statistics bundle for parity_check_ctrl.
interface parity_check_ctrl_if
  import parity_types_pkg::*;
#(
  parameter int BITWIDTH  = 8,
  parameter int CNT_WIDTH = 16
) ();

  logic                 cfgWe;
  parity_t              cfgParityType;
  parity_t              activeParityType;
  logic                 inValid;
  logic                 inReady;
  logic [BITWIDTH:0]    inData;
  logic                 outValid;
  logic                 outReady;
  logic [BITWIDTH-1:0]  outData;
  logic                 outParityOk;
  logic                 errClr;
  logic [CNT_WIDTH-1:0] errCount;
  logic                 errFlag;
  logic                 busy;

  modport master (
    output cfgWe, cfgParityType, inValid, inData, outReady, errClr,
    input  activeParityType, inReady, outValid, outData, outParityOk,
           errCount, errFlag, busy
  );

  modport slave (
    input  cfgWe, cfgParityType, inValid, inData, outReady, errClr,
    output activeParityType, inReady, outValid, outData, outParityOk,
           errCount, errFlag, busy
  );

endinterface

// File: rtl/parity_check.sv
// Combinational parity check of a {data, parityBit} word against a parity type.
module parity_check
  import parity_types_pkg::*;
#(
  parameter int BITWIDTH = 8
) (
  input  logic [BITWIDTH:0] word,
  input  parity_t           parity_type,
  output logic              ok
);

  always_comb begin
    ok = 1'b1;
    unique case (parity_type)
      EVEN:    ok = ~^word;
      ODD:     ok = ^word;
      MARK:    ok = word[0];
      SPACE:   ok = ~word[0];
      default: ok = 1'b1;
    endcase
  end

endmodule

// File: rtl/parity_check_ctrl.sv
// Valid/ready wrapper around parity_check with drained config update and error stats.
// Optional build macro PARITY_CTRL_DROP_EN: failing words are counted but not forwarded.
module parity_check_ctrl
  import parity_types_pkg::*;
#(
  parameter int      BITWIDTH     = 8,
  parameter int      CNT_WIDTH    = 16,
  parameter parity_t RESET_PARITY = NONE
) (
  input logic               clk,
  input logic               rstN,
  parity_check_ctrl_if.slave bus
);

`ifdef PARITY_CTRL_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  parity_ctrl_state_t    state;
  parity_t               active_type;
  parity_t               pending_type;
  logic                  out_valid;
  logic                  busy_r;
  logic [BITWIDTH-1:0]   out_data;
  logic                  out_ok;
  logic [CNT_WIDTH-1:0]  err_count;
  logic                  err_flag;

  logic word_ok;
  logic ready;
  logic accept;
  logic fail;
  logic keep;
  logic hold_busy;

  parity_check #(.BITWIDTH(BITWIDTH)) u_check (
    .word        (bus.inData),
    .parity_type (active_type),
    .ok          (word_ok)
  );

  assign ready     = (state == IDLE) || ((state == BUSY) && bus.outReady);
  assign accept    = bus.inValid && ready;
  assign fail      = accept && !word_ok;
  assign keep      = accept && (word_ok || !DROP_EN);
  // In BUSY the register stays occupied unless the consumer takes it and nothing replaces it.
  assign hold_busy = keep || !bus.outReady;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state        <= IDLE;
      active_type  <= RESET_PARITY;
      pending_type <= RESET_PARITY;
      out_valid    <= 1'b0;
      busy_r       <= 1'b0;
      out_data     <= '0;
      out_ok       <= 1'b0;
    end else begin
      if (keep) begin
        out_data <= bus.inData[BITWIDTH:1];
        out_ok   <= word_ok;
      end
      unique case (state)
        IDLE: begin
          if (keep) begin
            out_valid <= 1'b1;
            busy_r    <= 1'b1;
            if (bus.cfgWe) begin
              pending_type <= bus.cfgParityType;
              state        <= DRAIN;
            end else begin
              state <= BUSY;
            end
          end else if (bus.cfgWe) begin
            active_type <= bus.cfgParityType;
          end
        end
        BUSY: begin
          if (!hold_busy) begin
            out_valid <= 1'b0;
            busy_r    <= 1'b0;
            state     <= IDLE;
            if (bus.cfgWe) active_type <= bus.cfgParityType;
          end else if (bus.cfgWe) begin
            pending_type <= bus.cfgParityType;
            state        <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.cfgWe) pending_type <= bus.cfgParityType;
          if (bus.outReady) begin
            active_type <= bus.cfgWe ? bus.cfgParityType : pending_type;
            out_valid   <= 1'b0;
            busy_r      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy_r    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      err_count <= '0;
      err_flag  <= 1'b0;
    end else if (bus.errClr) begin
      err_count <= fail ? CNT_ONE : '0;
      err_flag  <= fail;
    end else if (fail) begin
      if (err_count != CNT_MAX) err_count <= err_count + CNT_ONE;
      err_flag <= 1'b1;
    end
  end

  assign bus.activeParityType = active_type;
  assign bus.inReady          = ready;
  assign bus.outValid         = out_valid;
  assign bus.outData          = out_data;
  assign bus.outParityOk      = out_ok;
  assign bus.errCount         = err_count;
  assign bus.errFlag          = err_flag;
  assign bus.busy             = busy_r;

endmodule

// File: tb/tb_parity_check_ctrl.sv
// Bench for parity_check_ctrl: directed literal checks plus randomized traffic against a queue model.
module tb_parity_check_ctrl;
  import parity_types_pkg::*;

  localparam int BW = 8;
  localparam int CW = 2;
`ifdef PARITY_CTRL_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  parity_check_ctrl_if #(.BITWIDTH(BW), .CNT_WIDTH(CW)) bus ();

  parity_check_ctrl #(.BITWIDTH(BW), .CNT_WIDTH(CW), .RESET_PARITY(NONE)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the output register is a queue of at most one word.
  typedef struct {
    logic [BW-1:0] d;
    logic          ok;
  } word_t;

  word_t   q[$];
  parity_t m_active = NONE;
  parity_t m_pend   = NONE;
  bit      m_pend_v = 1'b0;
  int      m_cnt    = 0;
  bit      m_flag   = 1'b0;

  function automatic bit model_ok(logic [BW:0] w, parity_t t);
    case (t)
      EVEN:    return ($countones(w) % 2) == 0;
      ODD:     return ($countones(w) % 2) == 1;
      MARK:    return w[0] == 1'b1;
      SPACE:   return w[0] == 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit m_ready();
    return !m_pend_v && (q.size() == 0 || bus.outReady);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rstN);
      if (!rstN) begin
        q.delete();
        m_active = NONE;
        m_pend   = NONE;
        m_pend_v = 1'b0;
        m_cnt    = 0;
        m_flag   = 1'b0;
      end else begin : upd
        bit    acc, ok, fire;
        word_t w;
        acc  = bus.inValid && m_ready();
        ok   = model_ok(bus.inData, m_active);
        fire = (q.size() > 0) && bus.outReady;
        if (fire) void'(q.pop_front());
        if (bus.errClr) begin
          m_cnt  = (acc && !ok) ? 1 : 0;
          m_flag = acc && !ok;
        end else if (acc && !ok) begin
          if (m_cnt < (1 << CW) - 1) m_cnt++;
          m_flag = 1'b1;
        end
        if (acc && (ok || !DROP)) begin
          w.d  = bus.inData[BW:1];
          w.ok = ok;
          q.push_back(w);
        end
        if (m_pend_v) begin
          if (bus.cfgWe) m_pend = bus.cfgParityType;
          if (fire) begin
            m_active = m_pend;
            m_pend_v = 1'b0;
          end
        end else if (bus.cfgWe) begin
          if (q.size() > 0) begin
            m_pend   = bus.cfgParityType;
            m_pend_v = 1'b1;
          end else begin
            m_active = bus.cfgParityType;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rstN && chk_en) begin
        chk("out_valid", 32'(bus.outValid), 32'(q.size() > 0));
        if (q.size() > 0) begin
          chk("out_data", 32'(bus.outData), 32'(q[0].d));
          chk("out_ok", 32'(bus.outParityOk), 32'(q[0].ok));
        end
        chk("in_ready", 32'(bus.inReady), 32'(m_ready()));
        chk("err_count", 32'(bus.errCount), 32'(m_cnt));
        chk("err_flag", 32'(bus.errFlag), 32'(m_flag));
        chk("active_type", 32'(bus.activeParityType), 32'(m_active));
        chk("busy", 32'(bus.busy), 32'(q.size() > 0));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.inValid = 1'b0;
    bus.cfgWe   = 1'b0;
    bus.errClr  = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    idle_in();
    bus.inData        = '0;
    bus.outReady      = 1'b1;
    bus.cfgParityType = NONE;
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
    chk_en = 1'b1;

    chk("rst_out_valid", 32'(bus.outValid), 0);
    chk("rst_err_count", 32'(bus.errCount), 0);
    chk("rst_err_flag", 32'(bus.errFlag), 0);
    chk("rst_active", 32'(bus.activeParityType), 32'(NONE));
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_in_ready", 32'(bus.inReady), 1);

`ifndef PARITY_CTRL_DROP_EN
    // NONE passes everything, one cycle latency
    bus.inValid = 1'b1; bus.inData = 9'h1FF;
    step();
    chk("t1_valid", 32'(bus.outValid), 1);
    chk("t1_data", 32'(bus.outData), 32'h FF);
    chk("t1_ok", 32'(bus.outParityOk), 1);
    bus.inValid = 1'b0;
    step();
    chk("t1_drained", 32'(bus.outValid), 0);

    // MARK in IDLE applies next edge
    bus.cfgWe = 1'b1; bus.cfgParityType = MARK;
    step();
    bus.cfgWe = 1'b0;
    chk("t2_active", 32'(bus.activeParityType), 32'(MARK));
    bus.inValid = 1'b1; bus.inData = 9'h001;
    step();
    chk("t2_ok1", 32'(bus.outParityOk), 1);
    bus.inData = 9'h000;
    step();
    chk("t2_ok0", 32'(bus.outParityOk), 0);
    bus.inValid = 1'b0;
    step();
    chk("t2_cnt", 32'(bus.errCount), 1);
    chk("t2_flag", 32'(bus.errFlag), 1);

    // SPACE with a stalled consumer
    bus.cfgWe = 1'b1; bus.cfgParityType = SPACE;
    step();
    bus.cfgWe = 1'b0;
    bus.outReady = 1'b0; bus.inValid = 1'b1; bus.inData = 9'h0A0;
    step();
    chk("t3_valid", 32'(bus.outValid), 1);
    chk("t3_data", 32'(bus.outData), 32'h50);
    bus.inData = 9'h0B1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_stall_ready", 32'(bus.inReady), 0);
      chk("t3_stall_data", 32'(bus.outData), 32'h50);
    end
    bus.outReady = 1'b1;
    step();
    chk("t3_next_data", 32'(bus.outData), 32'h58);
    chk("t3_next_ok", 32'(bus.outParityOk), 0);
    bus.inValid = 1'b0;
    step();
    chk("t3_empty", 32'(bus.outValid), 0);
    chk("t3_cnt", 32'(bus.errCount), 2);

    // cfg while BUSY waits for the handshake
    bus.outReady = 1'b0; bus.inValid = 1'b1; bus.inData = 9'h003;
    step();
    chk("t4_cnt_sat", 32'(bus.errCount), 3);
    bus.inValid = 1'b0; bus.cfgWe = 1'b1; bus.cfgParityType = EVEN;
    step();
    bus.cfgWe = 1'b0;
    chk("t4_drain_busy", 32'(bus.busy), 1);
    chk("t4_drain_ready", 32'(bus.inReady), 0);
    chk("t4_old_active", 32'(bus.activeParityType), 32'(SPACE));
    bus.inValid = 1'b1; bus.inData = 9'h002;
    step();
    chk("t4_blocked", 32'(bus.inReady), 0);
    step();
    chk("t4_held_data", 32'(bus.outData), 32'h01);
    bus.outReady = 1'b1;
    step();
    chk("t4_new_active", 32'(bus.activeParityType), 32'(EVEN));
    chk("t4_released", 32'(bus.outValid), 0);
    step();
    chk("t4_even_valid", 32'(bus.outValid), 1);
    chk("t4_even_ok", 32'(bus.outParityOk), 0);
    bus.inValid = 1'b0;
    step();

    // clear interaction and saturation
    bus.errClr = 1'b1; bus.inValid = 1'b1; bus.inData = 9'h002;
    step();
    chk("t5_clr_fail_cnt", 32'(bus.errCount), 1);
    chk("t5_clr_fail_flag", 32'(bus.errFlag), 1);
    bus.inValid = 1'b0;
    step();
    chk("t5_clr_cnt", 32'(bus.errCount), 0);
    chk("t5_clr_flag", 32'(bus.errFlag), 0);
    bus.errClr = 1'b0; bus.inValid = 1'b1;
    repeat (5) step();
    bus.inValid = 1'b0;
    step();
    chk("t5_sat", 32'(bus.errCount), 3);
`else
    // failing words are counted but never presented
    bus.cfgWe = 1'b1; bus.cfgParityType = SPACE;
    step();
    bus.cfgWe = 1'b0;
    bus.inValid = 1'b1; bus.inData = 9'h001;
    step();
    chk("t6_dropped", 32'(bus.outValid), 0);
    chk("t6_cnt", 32'(bus.errCount), 1);
    bus.inData = 9'h0A0;
    step();
    chk("t6_valid", 32'(bus.outValid), 1);
    chk("t6_data", 32'(bus.outData), 32'h50);
    chk("t6_ok", 32'(bus.outParityOk), 1);
    bus.inValid = 1'b0;
    step();
    chk("t6_cnt_end", 32'(bus.errCount), 1);
    chk("t6_empty", 32'(bus.outValid), 0);
`endif

    // asynchronous reset while holding a word
    bus.outReady = 1'b0; bus.inValid = 1'b1; bus.inData = 9'h1FE;
    step();
    chk("rst_mid_valid", 32'(bus.outValid), 1);
    bus.inValid = 1'b0;
    #2 rstN = 1'b0;
    #1;
    chk("rst_async_valid", 32'(bus.outValid), 0);
    chk("rst_async_busy", 32'(bus.busy), 0);
    chk("rst_async_active", 32'(bus.activeParityType), 32'(NONE));
    @(posedge clk);
    #1 rstN = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      bus.inData        = r[BW:0];
      bus.inValid       = ($urandom_range(0, 9) < 7);
      bus.outReady      = ($urandom_range(0, 9) < 6);
      bus.cfgWe         = ($urandom_range(0, 19) == 0);
      bus.cfgParityType = parity_t'($urandom_range(0, 4));
      bus.errClr        = ($urandom_range(0, 29) == 0);
      step();
    end

    idle_in();
    bus.outReady = 1'b1;
    repeat (4) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
